even_pipe_issue: RTL and testbench
==================================

// Module: even_pipe_issue
// PURPOSE
//  Issue stage feeding even_pipe: accepts one decoded instruction/cycle (valid/ready), reads RA/RB from RF, resolves RAW hazards vs. even-pipe in-flight results.
//  Forwards from even_pipe stage outputs s2..s7 / out_RT, or stalls; drives even_pipe opcode/operand/immediate/RT_addr inputs.
//  Sits between decode and even_pipe; own shadow scoreboard mirrors the 8-stage even_pipe write pipeline.
// PARAMETERS
//  OPCODE_LEN   11   opcode width (Opcodes enum)
//  REG_ADDR_WD  7    register address width (128 regs)
//  REG_DATA_WD  128  register data width
//  NOP_OPCODE   0    non-writing opcode driven when not issuing
//  STALL_CNT_WD 16   stall counter width
// PORTS
//  clk           in   1    clock
//  rst_n         in   1    reset
//  flush         in   1    drop held instruction
//  dec_valid     in   1    decode offers instruction
//  dec_ready     out  1    issue accepts instruction
//  dec_opcode    in   OPCODE_LEN  opcode
//  dec_ra_addr   in   7    RA address;  dec_rb_addr in 7 RB address
//  dec_rt_addr   in   7    RT address
//  dec_src_use   in   2    [0]=RA used, [1]=RB used
//  dec_imm       in   18   raw immediate
//  rf_ra_addr    out  7    RF read addr A;  rf_rb_addr out 7 RF read addr B
//  rf_ra_data    in   128  RF read data A (combinational);  rf_rb_data in 128 B
//  ep_rf_addr_s2..s7  in 7   even_pipe stage RT addresses
//  ep_rf_data_s2..s7  in 128 even_pipe stage RT data
//  ep_out_RT_addr in  7    even_pipe final addr;  ep_out_RT in 128 final data
//  ep_opcode     out  OPCODE_LEN  to even_pipe.opcode
//  ep_RA, ep_RB, ep_RC  out 128  operands (ep_RC = 0)
//  ep_I7/I8/I10/I16/I18 out 7/8/10/16/18  dec_imm[6:0]/[7:0]/[9:0]/[15:0]/[17:0]
//  ep_RT_addr    out  7    destination
//  issue_fire    out  1    instruction enters even_pipe this cycle
//  stall_cnt     out  STALL_CNT_WD  saturating count of hazard-stall cycles
// BEHAVIOUR
//  Reset: one clock; reset is asynchronous and active-low. rst_n=0 -> state IDLE, held regs 0, scoreboard valid 0, stall_cnt 0.
//   dec_ready=0 while rst_n=0; ep_opcode=NOP_OPCODE, issue_fire=0, ep_* data 0.
//  FSM: IDLE (no held instr) / HOLD (instr latched, evaluating).
//   IDLE: dec_ready=1; dec_valid -> latch, HOLD.
//   HOLD: fire = ~hazard; dec_ready = fire; fire&dec_valid -> relatch, stay HOLD; fire&~dec_valid -> IDLE; ~fire -> stay.
//   flush: held instr dropped, -> IDLE, dec_ready=0 that cycle, no fire; in-flight scoreboard entries kept.
//  Outputs combinational from held regs; ep_opcode = fire ? held opcode : NOP_OPCODE.
//  Scoreboard sb[1..8] {vld,addr}: shifts every cycle; sb[1] <= {fire, held rt}. sb[d] = instr issued d cycles ago.
//   sb[1] maps to even_pipe s1 (not exported), sb[2..7] -> s2..s7, sb[8] -> out_RT.
//  Per used source: youngest matching valid entry d (smallest d wins).
//   d=1 -> hazard (stall). d=2..7 -> ep_rf_data_s<d>. d=8 -> ep_out_RT. none -> RF data.
//   RF writes on rt_wr_en_ep edge; RF read reflects it the next cycle (d>=9).
//  RA==RB both matching: each source resolved independently, same result.
//  stall_cnt +1 per HOLD cycle with hazard, saturates at all-ones.
// CONFIGURATION
//  EVEN_ISSUE_FWD_EN defined: forwarding as above; min dependent distance 2.
//  Not defined: no forward muxes; any match d=1..8 -> hazard; operands always from RF; dependent distance 9.
// TESTING
//  Independent ADD_WORD x4 back-to-back, dec_valid held 1 -> issue_fire 4 consecutive cycles, stall_cnt=0.
//  ILW r5 then AW r6=r5+r7 next cycle (FWD_EN) -> 1 stall, AW fires +2, ep_RA==ep_rf_data_s2_ep, stall_cnt=1.
//  Same pair without FWD_EN -> AW fires 9 cycles after ILW, stall_cnt=8, ep_RA from rf_ra_data.
//  Two writers to r3 at T, T+3; reader at T+5 -> ep_RA from s2 (younger), not s5.
//  flush asserted in HOLD with hazard, dec_valid=1 -> no fire, dec_ready=0, IDLE next; following instr accepted next cycle.
//  rst_n low mid-stall (async) -> outputs at reset values immediately, scoreboard cleared, dec_ready=1 after release.

Source files
------------

// File: rtl/even_pipe_issue.sv
// Issue stage for even_pipe: holds one decoded instruction, resolves RAW hazards with a shadow
// scoreboard of the 8-stage write pipeline. Optional forwarding enabled by EVEN_ISSUE_FWD_EN.
module even_pipe_issue #(
  parameter int unsigned OPCODE_LEN   = 11,
  parameter int unsigned REG_ADDR_WD  = 7,
  parameter int unsigned REG_DATA_WD  = 128,
  parameter logic [OPCODE_LEN-1:0] NOP_OPCODE = '0,
  parameter int unsigned STALL_CNT_WD = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    dec_valid,
  output logic                    dec_ready,
  input  logic [OPCODE_LEN-1:0]   dec_opcode,
  input  logic [REG_ADDR_WD-1:0]  dec_ra_addr,
  input  logic [REG_ADDR_WD-1:0]  dec_rb_addr,
  input  logic [REG_ADDR_WD-1:0]  dec_rt_addr,
  input  logic [1:0]              dec_src_use,
  input  logic [17:0]             dec_imm,
  output logic [REG_ADDR_WD-1:0]  rf_ra_addr,
  output logic [REG_ADDR_WD-1:0]  rf_rb_addr,
  input  logic [REG_DATA_WD-1:0]  rf_ra_data,
  input  logic [REG_DATA_WD-1:0]  rf_rb_data,
  input  logic [REG_ADDR_WD-1:0]  ep_rf_addr_s2,
  input  logic [REG_ADDR_WD-1:0]  ep_rf_addr_s3,
  input  logic [REG_ADDR_WD-1:0]  ep_rf_addr_s4,
  input  logic [REG_ADDR_WD-1:0]  ep_rf_addr_s5,
  input  logic [REG_ADDR_WD-1:0]  ep_rf_addr_s6,
  input  logic [REG_ADDR_WD-1:0]  ep_rf_addr_s7,
  input  logic [REG_DATA_WD-1:0]  ep_rf_data_s2,
  input  logic [REG_DATA_WD-1:0]  ep_rf_data_s3,
  input  logic [REG_DATA_WD-1:0]  ep_rf_data_s4,
  input  logic [REG_DATA_WD-1:0]  ep_rf_data_s5,
  input  logic [REG_DATA_WD-1:0]  ep_rf_data_s6,
  input  logic [REG_DATA_WD-1:0]  ep_rf_data_s7,
  input  logic [REG_ADDR_WD-1:0]  ep_out_RT_addr,
  input  logic [REG_DATA_WD-1:0]  ep_out_RT,
  output logic [OPCODE_LEN-1:0]   ep_opcode,
  output logic [REG_DATA_WD-1:0]  ep_RA,
  output logic [REG_DATA_WD-1:0]  ep_RB,
  output logic [REG_DATA_WD-1:0]  ep_RC,
  output logic [6:0]              ep_I7,
  output logic [7:0]              ep_I8,
  output logic [9:0]              ep_I10,
  output logic [15:0]             ep_I16,
  output logic [17:0]             ep_I18,
  output logic [REG_ADDR_WD-1:0]  ep_RT_addr,
  output logic                    issue_fire,
  output logic [STALL_CNT_WD-1:0] stall_cnt
);

  typedef enum logic {StIdle, StHold} state_e;

  state_e                  state_q, state_d;
  logic [OPCODE_LEN-1:0]   op_q;
  logic [REG_ADDR_WD-1:0]  ra_q, rb_q, rt_q;
  logic [1:0]              use_q;
  logic [17:0]             imm_q;
  logic [STALL_CNT_WD-1:0] stall_q;
  logic [8:1]              sb_vld_q;
  logic [REG_ADDR_WD-1:0]  sb_addr_q [1:8];

  logic                    latch, hazard, ra_haz, rb_haz, fire, hold;
  logic [3:0]              ra_dist, rb_dist;
  logic [REG_DATA_WD-1:0]  ra_opnd, rb_opnd;

  // Stage addresses are redundant with the internal scoreboard.
  logic unused_inputs;
`ifdef EVEN_ISSUE_FWD_EN
  assign unused_inputs = ^{ep_rf_addr_s2, ep_rf_addr_s3, ep_rf_addr_s4, ep_rf_addr_s5,
                           ep_rf_addr_s6, ep_rf_addr_s7, ep_out_RT_addr};
`else
  assign unused_inputs = ^{ep_rf_addr_s2, ep_rf_addr_s3, ep_rf_addr_s4, ep_rf_addr_s5,
                           ep_rf_addr_s6, ep_rf_addr_s7, ep_out_RT_addr,
                           ep_rf_data_s2, ep_rf_data_s3, ep_rf_data_s4, ep_rf_data_s5,
                           ep_rf_data_s6, ep_rf_data_s7, ep_out_RT};
`endif

  assign hold = (state_q == StHold);

  // Descending scan so the youngest (smallest distance) match wins.
  always_comb begin
    ra_dist = '0;
    rb_dist = '0;
    for (int d = 8; d >= 1; d--) begin
      if (sb_vld_q[d] && sb_addr_q[d] == ra_q) ra_dist = 4'(d);
      if (sb_vld_q[d] && sb_addr_q[d] == rb_q) rb_dist = 4'(d);
    end
  end

`ifdef EVEN_ISSUE_FWD_EN
  assign ra_haz = use_q[0] && (ra_dist == 4'd1);
  assign rb_haz = use_q[1] && (rb_dist == 4'd1);

  always_comb begin
    ra_opnd = rf_ra_data;
    case (ra_dist)
      4'd2:    ra_opnd = ep_rf_data_s2;
      4'd3:    ra_opnd = ep_rf_data_s3;
      4'd4:    ra_opnd = ep_rf_data_s4;
      4'd5:    ra_opnd = ep_rf_data_s5;
      4'd6:    ra_opnd = ep_rf_data_s6;
      4'd7:    ra_opnd = ep_rf_data_s7;
      4'd8:    ra_opnd = ep_out_RT;
      default: ra_opnd = rf_ra_data;
    endcase
  end

  always_comb begin
    rb_opnd = rf_rb_data;
    case (rb_dist)
      4'd2:    rb_opnd = ep_rf_data_s2;
      4'd3:    rb_opnd = ep_rf_data_s3;
      4'd4:    rb_opnd = ep_rf_data_s4;
      4'd5:    rb_opnd = ep_rf_data_s5;
      4'd6:    rb_opnd = ep_rf_data_s6;
      4'd7:    rb_opnd = ep_rf_data_s7;
      4'd8:    rb_opnd = ep_out_RT;
      default: rb_opnd = rf_rb_data;
    endcase
  end
`else
  assign ra_haz  = use_q[0] && (ra_dist != 4'd0);
  assign rb_haz  = use_q[1] && (rb_dist != 4'd0);
  assign ra_opnd = rf_ra_data;
  assign rb_opnd = rf_rb_data;
`endif

  assign hazard = ra_haz || rb_haz;

  always_comb begin
    state_d   = state_q;
    latch     = 1'b0;
    fire      = hold && !hazard && !flush;
    dec_ready = rst_n && !flush && (!hold || fire);
    if (flush) begin
      state_d = StIdle;
    end else if (dec_ready && dec_valid) begin
      state_d = StHold;
      latch   = 1'b1;
    end else if (fire) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      rt_q    <= '0;
      use_q   <= '0;
      imm_q   <= '0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        op_q  <= dec_opcode;
        ra_q  <= dec_ra_addr;
        rb_q  <= dec_rb_addr;
        rt_q  <= dec_rt_addr;
        use_q <= dec_src_use;
        imm_q <= dec_imm;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q  <= '0;
      sb_vld_q <= '0;
      for (int d = 1; d <= 8; d++) sb_addr_q[d] <= '0;
    end else begin
      if (hold && hazard && stall_q != {STALL_CNT_WD{1'b1}}) begin
        stall_q <= stall_q + {{(STALL_CNT_WD-1){1'b0}}, 1'b1};
      end
      sb_vld_q     <= {sb_vld_q[7:1], fire};
      sb_addr_q[1] <= rt_q;
      for (int d = 2; d <= 8; d++) sb_addr_q[d] <= sb_addr_q[d-1];
    end
  end

  assign rf_ra_addr = ra_q;
  assign rf_rb_addr = rb_q;
  assign issue_fire = fire;
  assign ep_opcode  = fire ? op_q : NOP_OPCODE;
  assign ep_RA      = hold ? ra_opnd : '0;
  assign ep_RB      = hold ? rb_opnd : '0;
  assign ep_RC      = '0;
  assign ep_I7      = imm_q[6:0];
  assign ep_I8      = imm_q[7:0];
  assign ep_I10     = imm_q[9:0];
  assign ep_I16     = imm_q[15:0];
  assign ep_I18     = imm_q;
  assign ep_RT_addr = rt_q;
  assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_even_pipe_issue.sv
// Bench for even_pipe_issue: issue-history model checked every cycle plus directed scenarios.
module tb_even_pipe_issue;

`ifdef EVEN_ISSUE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam logic [10:0] OP_AW  = 11'h0C0;
  localparam logic [10:0] OP_ILW = 11'h081;

  logic clk, rst_n, flush, dec_valid, dec_ready, issue_fire;
  logic [10:0] dec_opcode, ep_opcode;
  logic [6:0] dec_ra_addr, dec_rb_addr, dec_rt_addr, rf_ra_addr, rf_rb_addr, ep_RT_addr;
  logic [1:0] dec_src_use;
  logic [17:0] dec_imm, ep_I18;
  logic [127:0] rf_ra_data, rf_rb_data, ep_RA, ep_RB, ep_RC;
  logic [127:0] ep_rf_data_s2, ep_rf_data_s3, ep_rf_data_s4, ep_rf_data_s5;
  logic [127:0] ep_rf_data_s6, ep_rf_data_s7, ep_out_RT;
  logic [6:0] ep_I7;
  logic [7:0] ep_I8;
  logic [9:0] ep_I10;
  logic [15:0] ep_I16, stall_cnt;

  function automatic logic [127:0] rf_val(input logic [6:0] a);
    return {16'hF11E, 105'h0, a};
  endfunction

  function automatic logic [127:0] stg_val(input int d);
    return {16'h57A6, 80'h0, 32'(d)};
  endfunction

  assign rf_ra_data    = rf_val(rf_ra_addr);
  assign rf_rb_data    = rf_val(rf_rb_addr);
  assign ep_rf_data_s2 = stg_val(2);
  assign ep_rf_data_s3 = stg_val(3);
  assign ep_rf_data_s4 = stg_val(4);
  assign ep_rf_data_s5 = stg_val(5);
  assign ep_rf_data_s6 = stg_val(6);
  assign ep_rf_data_s7 = stg_val(7);
  assign ep_out_RT     = stg_val(8);

  even_pipe_issue dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_opcode(dec_opcode), .dec_ra_addr(dec_ra_addr), .dec_rb_addr(dec_rb_addr),
    .dec_rt_addr(dec_rt_addr), .dec_src_use(dec_src_use), .dec_imm(dec_imm),
    .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr), .rf_ra_data(rf_ra_data),
    .rf_rb_data(rf_rb_data),
    .ep_rf_addr_s2(7'd0), .ep_rf_addr_s3(7'd0), .ep_rf_addr_s4(7'd0),
    .ep_rf_addr_s5(7'd0), .ep_rf_addr_s6(7'd0), .ep_rf_addr_s7(7'd0),
    .ep_rf_data_s2(ep_rf_data_s2), .ep_rf_data_s3(ep_rf_data_s3),
    .ep_rf_data_s4(ep_rf_data_s4), .ep_rf_data_s5(ep_rf_data_s5),
    .ep_rf_data_s6(ep_rf_data_s6), .ep_rf_data_s7(ep_rf_data_s7),
    .ep_out_RT_addr(7'd0), .ep_out_RT(ep_out_RT),
    .ep_opcode(ep_opcode), .ep_RA(ep_RA), .ep_RB(ep_RB), .ep_RC(ep_RC),
    .ep_I7(ep_I7), .ep_I8(ep_I8), .ep_I10(ep_I10), .ep_I16(ep_I16), .ep_I18(ep_I18),
    .ep_RT_addr(ep_RT_addr), .issue_fire(issue_fire), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: held-instruction slot plus a log of issued destinations stamped by cycle.
  typedef struct { int c; logic [6:0] rt; } iss_t;
  iss_t hist[$];
  int k;
  bit m_hold;
  logic [10:0] m_op;
  logic [6:0] m_ra, m_rb, m_rt;
  logic [1:0] m_use;
  logic [17:0] m_imm;
  int m_stall;
  int fire_log[$];
  logic [127:0] fire_ra[$];

  function automatic int youngest(input logic [6:0] a);
    int best = 0;
    foreach (hist[i]) begin
      if (hist[i].rt == a && (best == 0 || k - hist[i].c < best)) best = k - hist[i].c;
    end
    return best;
  endfunction

  function automatic bit is_haz(input int d);
    if (FWD) return d == 1;
    return d >= 1 && d <= 8;
  endfunction

  function automatic logic [127:0] opnd(input int d, input logic [6:0] a);
    if (FWD && d >= 2 && d <= 8) return stg_val(d);
    return rf_val(a);
  endfunction

  task automatic model_step();
    int da, db;
    bit haz, fire, rdy;
    da   = youngest(m_ra);
    db   = youngest(m_rb);
    haz  = (m_use[0] && is_haz(da)) || (m_use[1] && is_haz(db));
    fire = m_hold && !flush && !haz;
    rdy  = !flush && (!m_hold || fire);
    chk("issue_fire", issue_fire, fire);
    chk("dec_ready", dec_ready, rdy);
    chk("ep_opcode", ep_opcode, fire ? m_op : 11'd0);
    chk("stall_cnt", stall_cnt, m_stall);
    if (fire) begin
      chk("ep_RT_addr", ep_RT_addr, m_rt);
      chk("ep_I18", ep_I18, m_imm);
      chk("ep_I7", ep_I7, m_imm[6:0]);
      chk("ep_I16", ep_I16, m_imm[15:0]);
      chk("ep_RC", ep_RC, 128'd0);
      if (m_use[0]) chk("ep_RA", ep_RA, opnd(da, m_ra));
      if (m_use[1]) chk("ep_RB", ep_RB, opnd(db, m_rb));
    end
    if (issue_fire === 1'b1) begin
      fire_log.push_back(k);
      fire_ra.push_back(ep_RA);
    end
    if (m_hold && haz && m_stall < 65535) m_stall++;
    if (fire) hist.push_back('{c: k, rt: m_rt});
    if (flush) m_hold = 1'b0;
    else if (rdy && dec_valid) begin
      m_hold = 1'b1; m_op = dec_opcode; m_ra = dec_ra_addr; m_rb = dec_rb_addr;
      m_rt = dec_rt_addr; m_use = dec_src_use; m_imm = dec_imm;
    end else if (fire) m_hold = 1'b0;
    k++;
    while (hist.size() > 0 && k - hist[0].c > 16) void'(hist.pop_front());
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      hist.delete();
      m_hold = 1'b0;
      m_stall = 0;
      chk("rst_dec_ready", dec_ready, 1'b0);
      chk("rst_issue_fire", issue_fire, 1'b0);
      chk("rst_ep_opcode", ep_opcode, 11'd0);
      chk("rst_stall_cnt", stall_cnt, 16'd0);
      chk("rst_ep_RA", ep_RA, 128'd0);
    end else begin
      model_step();
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0; dec_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic set_dec(input logic [10:0] op, input logic [6:0] ra, input logic [6:0] rb,
                         input logic [6:0] rt, input logic [1:0] su, input logic [17:0] imm);
    dec_opcode = op; dec_ra_addr = ra; dec_rb_addr = rb; dec_rt_addr = rt;
    dec_src_use = su; dec_imm = imm;
  endtask

  task automatic send(input logic [10:0] op, input logic [6:0] ra, input logic [6:0] rb,
                      input logic [6:0] rt, input logic [1:0] su, input logic [17:0] imm);
    bit ok = 1'b0;
    set_dec(op, ra, rb, rt, su, imm);
    dec_valid = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (dec_ready) begin ok = 1'b1; break; end
    end
    chk("send_accepted", ok, 1'b1);
    @(posedge clk); #1 dec_valid = 1'b0;
  endtask

  task automatic wait_fires(input int target);
    for (int n = 0; n < 40 && fire_log.size() < target; n++) @(posedge clk);
    chk("fires_seen", fire_log.size() >= target, 1'b1);
  endtask

  int n0;

  initial begin
    k = 0; rst_n = 1'b0; flush = 1'b0; dec_valid = 1'b0;
    set_dec(11'd0, 7'd0, 7'd0, 7'd0, 2'd0, 18'd0);

    // Four independent adds back to back.
    do_reset();
    @(negedge clk);
    chk("idle_ready", dec_ready, 1'b1);
    @(posedge clk); #1;
    n0 = fire_log.size();
    for (int i = 0; i < 4; i++) send(OP_AW, 7'd1, 7'd2, 7'(10 + i), 2'b11, 18'(16'h1234 + i));
    wait_fires(n0 + 4);
    chk("b2b_span", 128'(fire_log[n0+3] - fire_log[n0]), 128'd3);
    chk("b2b_stall", stall_cnt, 16'd0);

    // Load r5, then dependent add r6 = r5 + r7.
    do_reset();
    n0 = fire_log.size();
    send(OP_ILW, 7'd0, 7'd0, 7'd5, 2'b00, 18'h2ABCD);
    send(OP_AW, 7'd5, 7'd7, 7'd6, 2'b11, 18'd0);
    wait_fires(n0 + 2);
    chk("dep_gap", 128'(fire_log[n0+1] - fire_log[n0]), FWD ? 128'd2 : 128'd9);
    chk("dep_stall", stall_cnt, FWD ? 16'd1 : 16'd8);
    chk("dep_RA", fire_ra[n0+1], FWD ? stg_val(2) : rf_val(7'd5));

    // Two writers to r3; reader must take the younger one.
    do_reset();
    n0 = fire_log.size();
    send(OP_ILW, 7'd0, 7'd0, 7'd3, 2'b00, 18'd1);
    send(OP_ILW, 7'd0, 7'd0, 7'd9, 2'b00, 18'd2);
    send(OP_ILW, 7'd0, 7'd0, 7'd10, 2'b00, 18'd3);
    send(OP_ILW, 7'd0, 7'd0, 7'd3, 2'b00, 18'd4);
    send(OP_ILW, 7'd0, 7'd0, 7'd11, 2'b00, 18'd5);
    send(OP_AW, 7'd3, 7'd20, 7'd12, 2'b01, 18'd6);
    wait_fires(n0 + 6);
    chk("waw_gap", 128'(fire_log[n0+5] - fire_log[n0+3]), FWD ? 128'd2 : 128'd9);
    chk("waw_RA", fire_ra[n0+5], FWD ? stg_val(2) : rf_val(7'd3));

    // Flush while holding a stalled instruction, with a new one offered.
    do_reset();
    send(OP_ILW, 7'd0, 7'd0, 7'd5, 2'b00, 18'd0);
    set_dec(OP_AW, 7'd5, 7'd7, 7'd6, 2'b01, 18'd0);
    dec_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    set_dec(OP_AW, 7'd1, 7'd2, 7'd40, 2'b00, 18'h155);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_fire", issue_fire, 1'b0);
    chk("flush_ready", dec_ready, 1'b0);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("post_flush_ready", dec_ready, 1'b1);
    chk("post_flush_fire", issue_fire, 1'b0);
    @(posedge clk); #1 dec_valid = 1'b0;
    @(negedge clk);
    chk("post_flush_issue", issue_fire, 1'b1);
    chk("post_flush_rt", ep_RT_addr, 7'd40);

    // Asynchronous reset in the middle of a stall.
    @(posedge clk); #1;
    do_reset();
    send(OP_ILW, 7'd0, 7'd0, 7'd5, 2'b00, 18'd0);
    set_dec(OP_AW, 7'd5, 7'd7, 7'd6, 2'b01, 18'd0);
    dec_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 dec_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_ready", dec_ready, 1'b0);
    chk("async_fire", issue_fire, 1'b0);
    chk("async_opcode", ep_opcode, 11'd0);
    chk("async_stall", stall_cnt, 16'd0);
    chk("async_RA", ep_RA, 128'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("release_ready", dec_ready, 1'b1);
    @(posedge clk); #1;
    n0 = fire_log.size();
    send(OP_AW, 7'd5, 7'd7, 7'd6, 2'b01, 18'd0);
    wait_fires(n0 + 1);
    chk("sb_cleared_stall", stall_cnt, 16'd0);
    chk("sb_cleared_RA", fire_ra[n0], rf_val(7'd5));

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
